// File: rtl/id_stage_pipe.sv
// RV32I decode stage fused with the ID/EX register as one elastic pipeline slot.
// Resolves operands with EX/MEM forwarding, stalls on load-use and flags illegal encodings.
module id_stage_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1,
    parameter bit          RV32E  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic [31:0]     inst_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            ex_wen_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic            ex_is_load_i,
    input  logic            mem_wen_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_wen_o,
    output logic            mem_ren_o,
    output logic            mem_wen_o,
    output logic            illegal_o
);

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    typedef struct packed {
        logic [XLEN-1:0] inst_addr;
        logic [31:0]     inst;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs2_val;
        logic [4:0]      rd;
        logic            reg_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic            illegal;
    } payload_t;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            legal, rs1_use, rs2_use, wr_cls;
    logic            rv32e_bad, illegal, hazard, in_ready, accept;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] v1, v2;
    payload_t        dec, pay_d, pay_q;
    logic            out_valid_d, out_valid_q;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        legal   = 1'b0;
        rs1_use = 1'b0;
        rs2_use = 1'b0;
        wr_cls  = 1'b0;
        case (opcode)
            OpcOpImm: begin
                rs1_use = 1'b1;
                wr_cls  = 1'b1;
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OpcOp: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                wr_cls  = 1'b1;
                legal   = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OpcBranch: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OpcJal: begin
                wr_cls = 1'b1;
                legal  = 1'b1;
            end
            OpcJalr: begin
                rs1_use = 1'b1;
                wr_cls  = 1'b1;
                legal   = (funct3 == 3'b000);
            end
            OpcLui, OpcAuipc: begin
                wr_cls = 1'b1;
                legal  = 1'b1;
            end
            OpcLoad: begin
                rs1_use = 1'b1;
                wr_cls  = 1'b1;
                legal   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OpcStore: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                legal   = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            default: legal = 1'b0;
        endcase
    end

    assign rv32e_bad = RV32E && ((rs1_use && rs1[4]) || (rs2_use && rs2[4]) || (wr_cls && rd[4]));
    assign illegal   = ~legal | rv32e_bad;
    assign rs1_addr  = (rs1_use && !illegal) ? rs1 : 5'd0;
    assign rs2_addr  = (rs2_use && !illegal) ? rs2 : 5'd0;

    // EX beats MEM because it holds the younger write to the same register.
    always_comb begin
        if (rs1_addr == 5'd0)                                  v1 = '0;
        else if (FWD_EN && ex_wen_i && (ex_rd_i == rs1_addr))  v1 = ex_wdata_i;
        else if (FWD_EN && mem_wen_i && (mem_rd_i == rs1_addr)) v1 = mem_wdata_i;
        else                                                   v1 = rs1_data_i;
        if (rs2_addr == 5'd0)                                  v2 = '0;
        else if (FWD_EN && ex_wen_i && (ex_rd_i == rs2_addr))  v2 = ex_wdata_i;
        else if (FWD_EN && mem_wen_i && (mem_rd_i == rs2_addr)) v2 = mem_wdata_i;
        else                                                   v2 = rs2_data_i;
    end

    always_comb begin
        dec           = '0;
        dec.inst_addr = inst_addr_i;
        dec.inst      = inst_i;
        dec.rs2_val   = v2;
        case (opcode)
            OpcOpImm: begin
                dec.op1 = v1;
                dec.op2 = ((funct3 == 3'b001) || (funct3 == 3'b101)) ?
                          {{(XLEN-5){1'b0}}, rs2} : imm_i;
                dec.imm = imm_i;
            end
            OpcOp: begin
                dec.op1 = v1;
                dec.op2 = ((funct3 == 3'b001) || (funct3 == 3'b101)) ?
                          {{(XLEN-5){1'b0}}, v2[4:0]} : v2;
            end
            OpcBranch: begin
                dec.op1 = v1;
                dec.op2 = v2;
                dec.imm = imm_b;
            end
            OpcJal: begin
                dec.op1 = inst_addr_i;
                dec.op2 = imm_j;
                dec.imm = imm_j;
            end
            OpcJalr: begin
                dec.op1 = v1;
                dec.op2 = imm_i;
                dec.imm = imm_i;
            end
            OpcLui: begin
                dec.op1 = imm_u;
                dec.imm = imm_u;
            end
            OpcAuipc: begin
                dec.op1 = inst_addr_i;
                dec.op2 = imm_u;
                dec.imm = imm_u;
            end
            OpcLoad: begin
                dec.op1     = v1;
                dec.op2     = imm_i;
                dec.imm     = imm_i;
                dec.mem_ren = 1'b1;
            end
            OpcStore: begin
                dec.op1     = v1;
                dec.op2     = imm_s;
                dec.imm     = imm_s;
                dec.mem_wen = 1'b1;
            end
            default: ;
        endcase
        dec.reg_wen = wr_cls && (rd != 5'd0);
        dec.rd      = dec.reg_wen ? rd : 5'd0;
        if (illegal) begin
            dec           = '0;
            dec.inst_addr = inst_addr_i;
            dec.inst      = inst_i;
            dec.illegal   = 1'b1;
        end
    end

    // Checked regardless of FWD_EN: a load result never exists before MEM.
    assign hazard   = in_valid_i & ex_wen_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                      ((ex_rd_i == rs1_addr) | (ex_rd_i == rs2_addr));
    assign in_ready = flush_i | (~hazard & (~out_valid_q | out_ready_i));
    assign accept   = in_valid_i & in_ready & ~flush_i;

    always_comb begin
        out_valid_d = out_valid_q;
        pay_d       = pay_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            pay_d       = dec;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            pay_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pay_q       <= pay_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign rs1_addr_o  = rs1_addr;
    assign rs2_addr_o  = rs2_addr;
    assign out_valid_o = out_valid_q;
    assign inst_addr_o = pay_q.inst_addr;
    assign inst_o      = pay_q.inst;
    assign op1_o       = pay_q.op1;
    assign op2_o       = pay_q.op2;
    assign imm_o       = pay_q.imm;
    assign rs2_val_o   = pay_q.rs2_val;
    assign rd_addr_o   = pay_q.rd;
    assign reg_wen_o   = pay_q.reg_wen;
    assign mem_ren_o   = pay_q.mem_ren;
    assign mem_wen_o   = pay_q.mem_wen;
    assign illegal_o   = pay_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: instance 0 default, 1 without forwarding, 2 with RV32E.
// All three share the same inputs.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, in_valid_i, out_ready_i;
    logic [31:0] inst_addr_i, inst_i, rs1_data_i, rs2_data_i;
    logic        ex_wen_i, ex_is_load_i, mem_wen_i;
    logic [4:0]  ex_rd_i, mem_rd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;

    logic        in_ready [3];
    logic        out_valid [3];
    logic        reg_wen [3];
    logic        mem_ren [3];
    logic        mem_wen [3];
    logic        illegal [3];
    logic [4:0]  rs1_addr [3];
    logic [4:0]  rs2_addr [3];
    logic [4:0]  rd [3];
    logic [31:0] pc_o [3];
    logic [31:0] inst_o [3];
    logic [31:0] op1 [3];
    logic [31:0] op2 [3];
    logic [31:0] imm [3];
    logic [31:0] rs2_val [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .FWD_EN(1'b1), .RV32E(1'b0)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready[0]), .inst_addr_i(inst_addr_i), .inst_i(inst_i),
        .rs1_addr_o(rs1_addr[0]), .rs2_addr_o(rs2_addr[0]),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_wen_i(mem_wen_i), .mem_rd_i(mem_rd_i),
        .mem_wdata_i(mem_wdata_i), .out_valid_o(out_valid[0]), .out_ready_i(out_ready_i),
        .inst_addr_o(pc_o[0]), .inst_o(inst_o[0]), .op1_o(op1[0]), .op2_o(op2[0]),
        .imm_o(imm[0]), .rs2_val_o(rs2_val[0]), .rd_addr_o(rd[0]), .reg_wen_o(reg_wen[0]),
        .mem_ren_o(mem_ren[0]), .mem_wen_o(mem_wen[0]), .illegal_o(illegal[0])
    );

    id_stage_pipe #(.XLEN(32), .FWD_EN(1'b0), .RV32E(1'b0)) u_nofwd (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready[1]), .inst_addr_i(inst_addr_i), .inst_i(inst_i),
        .rs1_addr_o(rs1_addr[1]), .rs2_addr_o(rs2_addr[1]),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_wen_i(mem_wen_i), .mem_rd_i(mem_rd_i),
        .mem_wdata_i(mem_wdata_i), .out_valid_o(out_valid[1]), .out_ready_i(out_ready_i),
        .inst_addr_o(pc_o[1]), .inst_o(inst_o[1]), .op1_o(op1[1]), .op2_o(op2[1]),
        .imm_o(imm[1]), .rs2_val_o(rs2_val[1]), .rd_addr_o(rd[1]), .reg_wen_o(reg_wen[1]),
        .mem_ren_o(mem_ren[1]), .mem_wen_o(mem_wen[1]), .illegal_o(illegal[1])
    );

    id_stage_pipe #(.XLEN(32), .FWD_EN(1'b1), .RV32E(1'b1)) u_rv32e (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready[2]), .inst_addr_i(inst_addr_i), .inst_i(inst_i),
        .rs1_addr_o(rs1_addr[2]), .rs2_addr_o(rs2_addr[2]),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_wen_i(mem_wen_i), .mem_rd_i(mem_rd_i),
        .mem_wdata_i(mem_wdata_i), .out_valid_o(out_valid[2]), .out_ready_i(out_ready_i),
        .inst_addr_o(pc_o[2]), .inst_o(inst_o[2]), .op1_o(op1[2]), .op2_o(op2[2]),
        .imm_o(imm[2]), .rs2_val_o(rs2_val[2]), .rd_addr_o(rd[2]), .reg_wen_o(reg_wen[2]),
        .mem_ren_o(mem_ren[2]), .mem_wen_o(mem_wen[2]), .illegal_o(illegal[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        inst_addr_i = '0; inst_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        ex_wen_i = 1'b0; ex_rd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
        mem_wen_i = 1'b0; mem_rd_i = '0; mem_wdata_i = '0;

        #12;
        chk("reset_out_valid", out_valid[0], 1'b0);
        chk("reset_op1", op1[0], 32'h0);
        chk("reset_rd", rd[0], 5'd0);
        chk("reset_reg_wen", reg_wen[0], 1'b0);
        rst = 1'b1;

        // addi x1,x0,5
        in_valid_i = 1'b1; out_ready_i = 1'b1; inst_addr_i = 32'h100; inst_i = 32'h00500093;
        #1 chk("addi_in_ready", in_ready[0], 1'b1);
        tick();
        chk("addi_valid", out_valid[0], 1'b1);
        chk("addi_op1", op1[0], 32'h0);
        chk("addi_op2", op2[0], 32'h5);
        chk("addi_rd", rd[0], 5'd1);
        chk("addi_reg_wen", reg_wen[0], 1'b1);
        chk("addi_imm", imm[0], 32'h5);
        chk("addi_rv32e_legal", illegal[2], 1'b0);

        // add x3,x1,x2 with EX forwarding x1 and MEM forwarding x2
        inst_addr_i = 32'h104; inst_i = 32'h002081B3;
        ex_wen_i = 1'b1; ex_rd_i = 5'd1; ex_wdata_i = 32'h7;
        mem_wen_i = 1'b1; mem_rd_i = 5'd2; mem_wdata_i = 32'h9;
        #1;
        chk("add_rs1_addr", rs1_addr[0], 5'd1);
        chk("add_rs2_addr", rs2_addr[0], 5'd2);
        tick();
        chk("add_fwd_op1", op1[0], 32'h7);
        chk("add_fwd_op2", op2[0], 32'h9);
        chk("add_rd", rd[0], 5'd3);
        chk("add_nofwd_op1", op1[1], 32'h0);
        chk("add_nofwd_op2", op2[1], 32'h0);

        // load-use hazard on x1
        ex_is_load_i = 1'b1; mem_wen_i = 1'b0;
        #1;
        chk("hazard_in_ready", in_ready[0], 1'b0);
        chk("hazard_in_ready_nofwd", in_ready[1], 1'b0);
        tick();
        chk("hazard_bubble", out_valid[0], 1'b0);
        chk("hazard_bubble_nofwd", out_valid[1], 1'b0);
        ex_is_load_i = 1'b0; ex_wdata_i = 32'h10;
        #1 chk("hazard_clear_in_ready", in_ready[0], 1'b1);
        tick();
        chk("hazard_accept_valid", out_valid[0], 1'b1);
        chk("hazard_accept_op1", op1[0], 32'h10);
        chk("hazard_accept_op1_nofwd", op1[1], 32'h0);

        // sw x5,12(x2)
        ex_wen_i = 1'b0; inst_addr_i = 32'h108; inst_i = 32'h00512623;
        rs1_data_i = 32'h100; rs2_data_i = 32'hAB;
        tick();
        chk("sw_op1", op1[0], 32'h100);
        chk("sw_op2", op2[0], 32'hC);
        chk("sw_rs2_val", rs2_val[0], 32'hAB);
        chk("sw_mem_wen", mem_wen[0], 1'b1);
        chk("sw_reg_wen", reg_wen[0], 1'b0);
        chk("sw_rd", rd[0], 5'd0);

        // nop: rs1 = x0 must read 0 despite nonzero register-file data
        inst_addr_i = 32'h10C; inst_i = 32'h00000013;
        tick();
        chk("nop_reg_wen", reg_wen[0], 1'b0);
        chk("nop_rd", rd[0], 5'd0);
        chk("nop_op1", op1[0], 32'h0);

        // backpressure: payload holds, new instruction waits
        out_ready_i = 1'b0; inst_addr_i = 32'h110; inst_i = 32'h00700113;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready[0], 1'b0);
            tick();
            chk("stall_valid", out_valid[0], 1'b1);
            chk("stall_inst", inst_o[0], 32'h00000013);
            chk("stall_pc", pc_o[0], 32'h10C);
        end
        flush_i = 1'b1;
        #1 chk("flush_in_ready", in_ready[0], 1'b1);
        tick();
        chk("flush_valid", out_valid[0], 1'b0);
        flush_i = 1'b0;

        // illegal opcode 0x7F
        out_ready_i = 1'b1; inst_addr_i = 32'h200; inst_i = 32'hFFFFFFFF;
        #1 chk("illegal_rs1_addr", rs1_addr[0], 5'd0);
        tick();
        chk("illegal_flag", illegal[0], 1'b1);
        chk("illegal_reg_wen", reg_wen[0], 1'b0);
        chk("illegal_mem_ren", mem_ren[0], 1'b0);
        chk("illegal_mem_wen", mem_wen[0], 1'b0);
        chk("illegal_rd", rd[0], 5'd0);
        chk("illegal_op1", op1[0], 32'h0);
        chk("illegal_imm", imm[0], 32'h0);
        chk("illegal_inst", inst_o[0], 32'hFFFFFFFF);
        chk("illegal_pc", pc_o[0], 32'h200);

        // addi x17,x0,1: legal on RV32I, illegal on RV32E
        inst_addr_i = 32'h204; inst_i = 32'h00100893;
        tick();
        chk("x17_rv32i_illegal", illegal[0], 1'b0);
        chk("x17_rv32i_rd", rd[0], 5'd17);
        chk("x17_rv32i_op2", op2[0], 32'h1);
        chk("x17_rv32e_illegal", illegal[2], 1'b1);
        chk("x17_rv32e_reg_wen", reg_wen[2], 1'b0);
        chk("x17_rv32e_rd", rd[2], 5'd0);

        // jal x1,8
        inst_addr_i = 32'h300; inst_i = 32'h008000EF;
        tick();
        chk("jal_op1", op1[0], 32'h300);
        chk("jal_op2", op2[0], 32'h8);
        chk("jal_rd", rd[0], 5'd1);

        // lw x4,8(x1): EX forward beats MEM forward
        inst_addr_i = 32'h304; inst_i = 32'h0080A203; rs1_data_i = 32'h200;
        ex_wen_i = 1'b1; ex_rd_i = 5'd1; ex_wdata_i = 32'h55;
        mem_wen_i = 1'b1; mem_rd_i = 5'd1; mem_wdata_i = 32'h66;
        tick();
        chk("lw_prio_op1", op1[0], 32'h55);
        chk("lw_op2", op2[0], 32'h8);
        chk("lw_mem_ren", mem_ren[0], 1'b1);
        chk("lw_reg_wen", reg_wen[0], 1'b1);
        chk("lw_rd", rd[0], 5'd4);
        chk("lw_nofwd_op1", op1[1], 32'h200);
        ex_wen_i = 1'b0;
        tick();
        chk("lw_mem_fwd_op1", op1[0], 32'h66);

        // hold, then asynchronous reset mid-transfer
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        tick();
        chk("hold_valid", out_valid[0], 1'b1);
        chk("hold_op1", op1[0], 32'h66);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid[0], 1'b0);
        chk("async_rst_op1", op1[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered, handshaked RV32I decode stage. It merges combinational decode and the ID/EX register into one elastic pipeline slot. Compared with the plain decoder, it adds:
- load/store decode,
- EX/MEM operand forwarding,
- load-use stall detection,
- flush,
- illegal-instruction flagging,
- valid/ready flow control on both sides.

It sits between the fetch register (if_id) and the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is legal.
- FWD_EN, 1, 1 enables EX/MEM forwarding; 0 reads register-file data only.
- RV32E, 0, 1 flags any rs1/rs2/rd index ≥ 16 as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  kill the held instruction and the incoming instruction.
- in_valid_i  in  1  if_id holds an instruction.
- in_ready_o  out  1  this stage accepts this cycle.
- inst_addr_i  in  XLEN  PC of the incoming instruction.
- inst_i  in  32  incoming instruction.
- rs1_addr_o  out  5  combinational register-file read address 1; 0 if unused.
- rs2_addr_o  out  5  combinational register-file read address 2; 0 if unused.
- rs1_data_i  in  XLEN  register-file read data 1.
- rs2_data_i  in  XLEN  register-file read data 2.
- ex_wen_i  in  1  EX-stage instruction will write ex_rd_i.
- ex_rd_i  in  5  EX-stage destination register.
- ex_wdata_i  in  XLEN  EX-stage result.
- ex_is_load_i  in  1  EX-stage instruction is a load; its result is not yet available.
- mem_wen_i  in  1  MEM-stage write enable.
- mem_rd_i  in  5  MEM-stage destination register.
- mem_wdata_i  in  XLEN  MEM-stage result.
- out_valid_o  out  1  registered payload is valid.
- out_ready_i  in  1  execute stage consumes the payload.
- inst_addr_o  out  XLEN  registered payload: PC.
- inst_o  out  32  registered payload: instruction.
- op1_o  out  XLEN  registered payload: operand 1.
- op2_o  out  XLEN  registered payload: operand 2.
- imm_o  out  XLEN  registered payload: sign-extended immediate.
- rs2_val_o  out  XLEN  registered payload: resolved rs2 value (store data).
- rd_addr_o  out  5  registered payload: destination register.
- reg_wen_o  out  1  registered payload: register write enable.
- mem_ren_o  out  1  registered payload: load.
- mem_wen_o  out  1  registered payload: store.
- illegal_o  out  1  registered payload: illegal instruction.

## Operation
Operand resolution applies to both rs1 and rs2, in priority order:
- Index 0 always resolves to 0.
- Otherwise, if FWD_EN and ex_wen_i and ex_rd_i matches, use ex_wdata_i.
- Otherwise, if FWD_EN and mem_wen_i and mem_rd_i matches, use mem_wdata_i.
- Otherwise, use the register-file data.

Decode by opcode (v1 = resolved rs1 value, v2 = resolved rs2 value):
- OP-IMM:
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI: op1=v1, op2=sext(imm[11:0]).
  - SLLI/SRLI/SRAI: op1=v1, op2={27'b0, shamt}.
- OP:
  - ADD/SUB/SLT/SLTU/XOR/OR/AND: op1=v1, op2=v2.
  - SLL/SRL/SRA: op1=v1, op2={27'b0, v2[4:0]}.
- BRANCH: op1=v1, op2=v2, imm=B-imm, reg_wen=0.
- JAL: op1=PC, op2=J-imm, imm=J-imm.
- JALR: op1=v1, op2=I-imm.
- LUI: op1={U, 12'b0}, op2=0.
- AUIPC: op1=PC, op2={U, 12'b0}.
- LOAD (0000011, funct3 in {000, 001, 010, 100, 101}): op1=v1, op2=I-imm, mem_ren=1.
- STORE (0100011, funct3 in {000, 001, 010}): op1=v1, op2=S-imm, rs2_val=v2, mem_wen=1, reg_wen=0.

Register-write rules:
- reg_wen_o = 1 only for writing classes (OP-IMM, OP, JAL, JALR, LUI, AUIPC, LOAD) with rd ≠ 0.
- rd_addr_o = 0 whenever reg_wen_o = 0.

Illegal instructions:
- Triggered by any other opcode/funct3, or a register index violation when RV32E = 1.
- Payload: illegal_o=1; op1, op2, imm, rd, and all enables are 0; PC and instruction are still passed.

Register use:
- rs1 is used by OP-IMM, OP, BRANCH, JALR, LOAD, STORE.
- rs2 is used by OP, BRANCH, STORE.

Load-use hazard:
- hazard = in_valid_i & ex_wen_i & ex_is_load_i & (ex_rd_i ≠ 0) & (ex_rd_i equals a used rs).
- The hazard is evaluated even when FWD_EN = 0.

Handshake:
- in_ready_o = flush_i | (~hazard & (~out_valid_o | out_ready_i)).
- Load condition: accept = in_valid_i & in_ready_o & ~flush_i.

## Timing
- Reset: every registered output is 0, including out_valid_o.
- Next-state priority (highest first):
  - flush_i: out_valid_o ← 0; the incoming instruction is discarded.
  - accept: payload ← decode; out_valid_o ← 1.
  - out_ready_i (no accept): out_valid_o ← 0.
  - otherwise: hold.
- Latency is 1 cycle. Full throughput, one instruction per cycle, when out_ready_i = 1 and there is no hazard.
- While out_valid_o & ~out_ready_i, the payload is bit-stable.
- A hazard with the slot consumable (out_valid_o = 0 or out_ready_i = 1) inserts a bubble: out_valid_o = 0 next cycle. The instruction stays held upstream and is accepted once ex_is_load_i clears.
- Accept and consume in the same cycle replaces the payload; there is no gap.
- Forwarding is sampled in the accept cycle only.
- rst asserted mid-transfer clears out_valid_o immediately; the payload is lost.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5) with rs1_data=0 and out_ready=1 -> the next cycle shows out_valid=1, op1=0, op2=5, rd=1, reg_wen=1.
- 0x002081B3 (add x3,x1,x2): ex_wen=1, ex_rd=1, ex_wdata=7; mem_wen=1, mem_rd=2, mem_wdata=9; rs data=0 -> op1=7, op2=9. Repeat with FWD_EN=0 -> op1=op2=0.
- ex_is_load=1, ex_rd=1, ex_wen=1 with add x3,x1,x2 pending -> in_ready=0 and out_valid=0 for one cycle. Then clear ex_is_load with ex_wdata=0x10 -> accepted, op1=0x10.
- 0x00512623 (sw x5,12(x2)) with rs1=0x100, rs2=0xAB -> op1=0x100, op2=12, rs2_val=0xAB, mem_wen=1, reg_wen=0. 0x00000013 (nop) -> reg_wen=0, rd=0.
- out_ready=0 for 3 cycles with a new in_valid -> payload unchanged and in_ready=0. Assert flush_i -> out_valid=0 next cycle and in_ready=1 during the flush.
- Opcode 0x7F -> illegal_o=1 with all enables 0. With RV32E=1, addi x17,x0,1 -> illegal_o=1.
